turn_input_conditioner: RTL and testbench

Upstream stage of the turn-signal FSM. Takes raw, asynchronous left/right switch inputs and synchronizes, debounces and optionally latches them. Drives clean, glitch-free, single-clock-domain `right`/`left` levels straight into the FSM's `right`/`left` inputs. One instance per board, between the input pins and the FSM.

---
 rtl/turn_input_conditioner_pkg.sv | 20 ++
 rtl/turn_input_conditioner_debounce_chan.sv | 95 +++++++++
 rtl/turn_input_conditioner.sv | 84 ++++++++
 tb/tb_turn_input_conditioner.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/turn_input_conditioner_pkg.sv
// Shared types and default sizing for the turn-signal input conditioner.
// Imported by debounce_chan and turn_input_conditioner.
package turn_cond_pkg;

  localparam int SYNC_STAGES_DEF     = 2;
  localparam int DEBOUNCE_CYCLES_DEF = 4;

  typedef enum logic [1:0] {
    IDLE,
    PEND_ON,
    ON,
    PEND_OFF
  } deb_state_t;

  // The debounced level is high once a press has been accepted, including while a release is pending.
  function automatic logic level_of(input deb_state_t st);
    return (st == ON) || (st == PEND_OFF);
  endfunction

endpackage

// File: rtl/turn_input_conditioner_debounce_chan.sv
// One input channel: multi-flop synchronizer followed by a four-state debounce FSM.
// The debounced level is registered from the FSM state so it is glitch-free.
module debounce_chan
  import turn_cond_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic db
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  deb_state_t             state;
  deb_state_t             state_nx;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_nx;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      db    <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      db    <= level_of(state);
    end
  end

  // Any sample disagreeing with the pending direction drops back and restarts the count;
  // on reaching the last count the counter is left as-is, so it can never wrap.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (s) begin
          state_nx = PEND_ON;
          cnt_nx   = CNT_ONE;
        end else begin
          cnt_nx = '0;
        end
      end
      PEND_ON: begin
        if (!s) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nx = ON;
        end else begin
          cnt_nx = cnt + CNT_ONE;
        end
      end
      ON: begin
        if (!s) begin
          state_nx = PEND_OFF;
          cnt_nx   = CNT_ONE;
        end
      end
      PEND_OFF: begin
        if (s) begin
          state_nx = ON;
          cnt_nx   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

endmodule

// File: rtl/turn_input_conditioner.sv
// Conditions raw left/right turn switches into clean levels for the turn-signal FSM.
// Optional `define TURN_LATCH_EN turns each output into a press-to-toggle latch.
module turn_input_conditioner
  import turn_cond_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic right_raw,
  input  logic left_raw,
  output logic right,
  output logic left,
  output logic hazard
);

  logic db_right;
  logic db_left;

  debounce_chan #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_right (
    .clk  (clk),
    .reset(reset),
    .raw  (right_raw),
    .db   (db_right)
  );

  debounce_chan #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_left (
    .clk  (clk),
    .reset(reset),
    .raw  (left_raw),
    .db   (db_left)
  );

`ifdef TURN_LATCH_EN
  logic db_right_d;
  logic db_left_d;
  logic rise_right;
  logic rise_left;
  logic req_right;
  logic req_left;

  assign rise_right = db_right & ~db_right_d;
  assign rise_left  = db_left & ~db_left_d;

  // A lone press on one side cancels the other side's request; simultaneous presses both toggle.
  always_ff @(posedge clk) begin
    if (reset) begin
      db_right_d <= 1'b0;
      db_left_d  <= 1'b0;
      req_right  <= 1'b0;
      req_left   <= 1'b0;
    end else begin
      db_right_d <= db_right;
      db_left_d  <= db_left;
      if (rise_right) begin
        req_right <= ~req_right;
      end else if (rise_left) begin
        req_right <= 1'b0;
      end
      if (rise_left) begin
        req_left <= ~req_left;
      end else if (rise_right) begin
        req_left <= 1'b0;
      end
    end
  end

  assign right = req_right;
  assign left  = req_left;
`else
  assign right = db_right;
  assign left  = db_left;
`endif

  assign hazard = right & left;

endmodule

// File: tb/tb_turn_input_conditioner.sv
// Self-checking bench for turn_input_conditioner: directed scenarios plus randomized switching,
// all compared against a sample-history reference model of synchronizer + debounce (+ latch).
module tb_turn_input_conditioner;

  localparam int SYNC = 2;
  localparam int DEB  = 4;
`ifdef TURN_LATCH_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic right_raw = 1'b0;
  logic left_raw = 1'b0;
  logic right;
  logic left;
  logic hazard;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: raw value captured at each edge since the last reset.
  bit hist[2][0:4095];
  int ecount = 0;
  bit m_lvl[2];
  bit m_db[2];
  bit m_dbp[2];
  bit m_req[2];

  turn_input_conditioner #(
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .right_raw(right_raw),
    .left_raw (left_raw),
    .right    (right),
    .left     (left),
    .hazard   (hazard)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  // Value the debounce logic sees at edge e: the raw value captured SYNC edges earlier, 0 right after reset.
  function automatic bit s_at(input int c, input int e);
    if (e > SYNC) return hist[c][e-SYNC];
    return 1'b0;
  endfunction

  task automatic model_edge(input bit rraw, input bit lraw, input bit rst);
    bit rise[2];
    bit flip;
    bit new_req0;
    bit new_req1;
    if (rst) begin
      ecount = 0;
      for (int c = 0; c < 2; c++) begin
        m_lvl[c] = 1'b0;
        m_db[c]  = 1'b0;
        m_dbp[c] = 1'b0;
        m_req[c] = 1'b0;
      end
      return;
    end
    ecount++;
    hist[0][ecount] = rraw;
    hist[1][ecount] = lraw;
    for (int c = 0; c < 2; c++) begin
      rise[c]  = m_db[c] & ~m_dbp[c];
      m_dbp[c] = m_db[c];
      m_db[c]  = m_lvl[c];
      // The level flips once the last DEB seen samples all disagree with it.
      flip = 1'b1;
      for (int j = 0; j < DEB; j++) begin
        if (s_at(c, ecount - j) == m_lvl[c]) flip = 1'b0;
      end
      if (flip) m_lvl[c] = ~m_lvl[c];
    end
    new_req0 = rise[0] ? ~m_req[0] : (rise[1] ? 1'b0 : m_req[0]);
    new_req1 = rise[1] ? ~m_req[1] : (rise[0] ? 1'b0 : m_req[1]);
    m_req[0] = new_req0;
    m_req[1] = new_req1;
  endtask

  function automatic logic [2:0] exp_out();
    logic r;
    logic l;
`ifdef TURN_LATCH_EN
    r = m_req[0];
    l = m_req[1];
`else
    r = m_db[0];
    l = m_db[1];
`endif
    return {r, l, r & l};
  endfunction

  task automatic applyStimulus(input bit r, input bit l, input bit rst);
    @(negedge clk);
    right_raw = r;
    left_raw  = l;
    reset     = rst;
    @(posedge clk);
    model_edge(r, l, rst);
    #1;
  endtask

  task automatic test_reset();
    logic [2:0] e;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(i[0], ~i[0], 1'b1);
      n_cmp++;
      if ({right, left, hazard} !== 3'b000) begin
        n_bad++;
        $display("[TB] FAIL reset_hold cyc=%0d: r/l/h=%b expected 000", i, {right, left, hazard});
      end
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    e = exp_out();
    n_cmp++;
    if ({right, left, hazard} !== 3'b000 || e !== 3'b000) begin
      n_bad++;
      $display("[TB] FAIL reset_release: r/l/h=%b model=%b expected 000", {right, left, hazard}, e);
    end
  endtask

  task automatic test_right_press();
    logic [2:0] e;
    applyStimulus(1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 20; k++) begin
      applyStimulus(k <= 10, 1'b0, 1'b0);
      e = exp_out();
      n_cmp++;
      if ({right, left, hazard} !== e) begin
        n_bad++;
        $display("[TB] FAIL right_press cyc=%0d: r/l/h=%b expected %b", k, {right, left, hazard}, e);
      end
      if (k <= 10) begin
        n_cmp++;
        if (right !== (k >= 7 + LAT)) begin
          n_bad++;
          $display("[TB] FAIL right_latency cyc=%0d: right=%b expected %b", k, right, k >= 7 + LAT);
        end
      end
`ifndef TURN_LATCH_EN
      if (k > 10) begin
        n_cmp++;
        if (right !== (k < 17)) begin
          n_bad++;
          $display("[TB] FAIL right_release cyc=%0d: right=%b expected %b", k, right, k < 17);
        end
      end
`endif
    end
  endtask

  task automatic test_bounce();
    bit pat[10] = '{1, 0, 1, 1, 0, 1, 1, 1, 1, 1};
    logic [2:0] e;
    logic prev;
    int rises;
    int first;
    applyStimulus(1'b0, 1'b0, 1'b1);
    prev  = 1'b0;
    rises = 0;
    first = 0;
    for (int k = 1; k <= 16; k++) begin
      applyStimulus((k <= 10) ? pat[k-1] : 1'b1, 1'b0, 1'b0);
      e = exp_out();
      n_cmp++;
      if ({right, left, hazard} !== e) begin
        n_bad++;
        $display("[TB] FAIL bounce cyc=%0d: r/l/h=%b expected %b", k, {right, left, hazard}, e);
      end
      if (right === 1'b1 && prev !== 1'b1) begin
        rises++;
        if (first == 0) first = k;
      end
      prev = right;
    end
    n_cmp++;
    if (rises != 1 || first != 12 + LAT) begin
      n_bad++;
      $display("[TB] FAIL bounce_edge: rises=%0d first=%0d expected rises=1 first=%0d", rises, first, 12 + LAT);
    end
    for (int k = 1; k <= 12; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      e = exp_out();
      n_cmp++;
      if ({right, left, hazard} !== e) begin
        n_bad++;
        $display("[TB] FAIL bounce_release cyc=%0d: r/l/h=%b expected %b", k, {right, left, hazard}, e);
      end
    end
  endtask

  task automatic test_both();
    logic [2:0] e;
    applyStimulus(1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 20; k++) begin
      applyStimulus(1'b1, k <= 10, 1'b0);
      e = exp_out();
      n_cmp++;
      if ({right, left, hazard} !== e) begin
        n_bad++;
        $display("[TB] FAIL both cyc=%0d: r/l/h=%b expected %b", k, {right, left, hazard}, e);
      end
      if (k <= 10) begin
        n_cmp++;
        if ({right, left, hazard} !== ((k >= 7 + LAT) ? 3'b111 : 3'b000)) begin
          n_bad++;
          $display("[TB] FAIL both_together cyc=%0d: r/l/h=%b expected %b", k, {right, left, hazard},
                   (k >= 7 + LAT) ? 3'b111 : 3'b000);
        end
      end
`ifndef TURN_LATCH_EN
      if (k > 10) begin
        n_cmp++;
        if (hazard !== (k < 17)) begin
          n_bad++;
          $display("[TB] FAIL hazard_release cyc=%0d: hazard=%b expected %b", k, hazard, k < 17);
        end
      end
`endif
    end
  endtask

  task automatic test_reset_mid();
    logic [2:0] e;
    applyStimulus(1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 15; k++) begin
      applyStimulus(k < 13, 1'b0, 1'b0);
      e = exp_out();
      n_cmp++;
      if ({right, left, hazard} !== e) begin
        n_bad++;
        $display("[TB] FAIL reset_mid_pre cyc=%0d: r/l/h=%b expected %b", k, {right, left, hazard}, e);
      end
    end
    applyStimulus(1'b1, 1'b0, 1'b1);
    n_cmp++;
    if ({right, left, hazard} !== 3'b000) begin
      n_bad++;
      $display("[TB] FAIL reset_mid_clear: r/l/h=%b expected 000", {right, left, hazard});
    end
    for (int j = 1; j <= 10; j++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      e = exp_out();
      n_cmp++;
      if ({right, left, hazard} !== e || right !== (j >= 7 + LAT)) begin
        n_bad++;
        $display("[TB] FAIL reset_mid_restart cyc=%0d: r/l/h=%b expected %b right=%b", j,
                 {right, left, hazard}, e, j >= 7 + LAT);
      end
    end
  endtask

  task automatic test_random();
    logic [2:0] e;
    int hold_r = 0;
    int hold_l = 0;
    bit vr = 1'b0;
    bit vl = 1'b0;
    bit rst;
    applyStimulus(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 400; i++) begin
      if (hold_r == 0) begin
        vr     = 1'($urandom_range(0, 1));
        hold_r = int'($urandom_range(1, 10));
      end
      if (hold_l == 0) begin
        vl     = 1'($urandom_range(0, 1));
        hold_l = int'($urandom_range(1, 10));
      end
      hold_r--;
      hold_l--;
      rst = ($urandom_range(0, 99) == 0);
      applyStimulus(vr, vl, rst);
      e = exp_out();
      n_cmp++;
      if ({right, left, hazard} !== e) begin
        n_bad++;
        $display("[TB] FAIL random cyc=%0d: r/l/h=%b expected %b", i, {right, left, hazard}, e);
      end
    end
  endtask

`ifdef TURN_LATCH_EN
  task automatic test_latch();
    logic [2:0] e;
    bit seen;
    applyStimulus(1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 20; k++) begin
      applyStimulus(k <= 8, 1'b0, 1'b0);
      e = exp_out();
      n_cmp++;
      if ({right, left, hazard} !== e) begin
        n_bad++;
        $display("[TB] FAIL latch_right cyc=%0d: r/l/h=%b expected %b", k, {right, left, hazard}, e);
      end
    end
    n_cmp++;
    if ({right, left} !== 2'b10) begin
      n_bad++;
      $display("[TB] FAIL latch_right_held: r/l=%b expected 10", {right, left});
    end
    seen = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      applyStimulus(1'b0, k <= 8, 1'b0);
      e = exp_out();
      n_cmp++;
      if ({right, left, hazard} !== e) begin
        n_bad++;
        $display("[TB] FAIL latch_left cyc=%0d: r/l/h=%b expected %b", k, {right, left, hazard}, e);
      end
      if (left === 1'b1 && !seen) begin
        seen = 1'b1;
        n_cmp++;
        if (right !== 1'b0) begin
          n_bad++;
          $display("[TB] FAIL latch_cross_clear cyc=%0d: right=%b expected 0", k, right);
        end
      end
    end
    n_cmp++;
    if ({right, left, seen} !== 3'b011) begin
      n_bad++;
      $display("[TB] FAIL latch_left_held: r/l/seen=%b expected 011", {right, left, seen});
    end
    for (int k = 1; k <= 20; k++) begin
      applyStimulus(1'b0, k <= 8, 1'b0);
      e = exp_out();
      n_cmp++;
      if ({right, left, hazard} !== e) begin
        n_bad++;
        $display("[TB] FAIL latch_left_again cyc=%0d: r/l/h=%b expected %b", k, {right, left, hazard}, e);
      end
    end
    n_cmp++;
    if ({right, left} !== 2'b00) begin
      n_bad++;
      $display("[TB] FAIL latch_left_toggle: r/l=%b expected 00", {right, left});
    end
  endtask
`endif

  initial begin
    $display("[TB] starting turn_input_conditioner bench");
    test_reset();
    test_right_press();
    test_bounce();
    test_both();
    test_reset_mid();
`ifdef TURN_LATCH_EN
    test_latch();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
